// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and counter sizing for the serializer
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } piso_state_t;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - frame bit position counter with terminal-count flag
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

  // clear (abort) and load (new frame) both restart at bit 0; enable advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parametrised parallel-in/serial-out serializer with handshake and markers
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             first,
  output logic             last,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  piso_state_t      state, state_d;
  logic [WIDTH-1:0] shift_reg, shift_d;
  logic             done_q, done_d;
  logic             cnt_clear, cnt_load, cnt_en;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .load   (cnt_load),
    .enable (cnt_en),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Ready in idle, or on the tick that consumes the final bit so frames chain gap-free
  assign load_ready = !flush && ((state == IDLE) || ((state == SHIFT) && tc && shift_en));
  assign accept     = load_valid && load_ready;

  // Next-state, shift register and counter control; flush overrides everything
  always_comb begin
    state_d   = state;
    shift_d   = shift_reg;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      shift_d   = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_d  = d;
            cnt_load = 1'b1;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (tc) begin
              done_d = 1'b1;
              if (accept) begin
                shift_d  = d;
                cnt_load = 1'b1;
              end else begin
                shift_d   = '0;
                cnt_clear = 1'b1;
                state_d   = IDLE;
              end
            end else begin
              shift_d = LSB_FIRST ? {1'b0, shift_reg[WIDTH-1:1]}
                                  : {shift_reg[WIDTH-2:0], 1'b0};
              cnt_en  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, data and done registers; reset drops any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      done_q    <= done_d;
    end
  end

  assign q       = (state == SHIFT) ? (LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1]) : IDLE_LEVEL;
  assign q_valid = (state == SHIFT);
  assign first   = (state == SHIFT) && (cnt == '0);
  assign last    = (state == SHIFT) && tc;
  assign done    = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       shift_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] d = 8'h00;

  logic q_m, qv_m, first_m, last_m, done_m, lr_m;
  logic q_l, qv_l, first_l, last_l, done_l, lr_l;
  logic [5:0] om, ol, em, el;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .flush(flush), .shift_en(shift_en), .d(d),
    .load_valid(load_valid), .load_ready(lr_m), .q(q_m), .q_valid(qv_m),
    .first(first_m), .last(last_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .reset(reset), .flush(flush), .shift_en(shift_en), .d(d),
    .load_valid(load_valid), .load_ready(lr_l), .q(q_l), .q_valid(qv_l),
    .first(first_l), .last(last_l), .done(done_l)
  );

  // observed vectors: {q, q_valid, first, last, done, load_ready}
  assign om = {q_m, qv_m, first_m, last_m, done_m, lr_m};
  assign ol = {q_l, qv_l, first_l, last_l, done_l, lr_l};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; d = 8'hFF; shift_en = 1'b1;
    nxt(); nxt(); #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL reset_m got=%b exp=%b", om, 6'b000001); end
    total++; if (ol !== 6'b100001) begin bad++; $display("FAIL reset_l got=%b exp=%b", ol, 6'b100001); end
    load_valid = 1'b0;
    reset = 1'b1;
    nxt(); #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", om, 6'b000001); end
  endtask

  task automatic test_frame();
    logic [7:0] bm, bl;
    bm = 8'b00000001;
    bl = 8'b10000000;
    nxt();
    d = 8'h01; load_valid = 1'b1; shift_en = 1'b1; #1;
    total++; if (lr_m !== 1'b1) begin bad++; $display("FAIL frame_ready got=%b exp=1", lr_m); end
    nxt();
    load_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      em = {bm[8-i], 1'b1, i == 1, i == 8, 1'b0, i == 8};
      el = {bl[8-i], 1'b1, i == 1, i == 8, 1'b0, i == 8};
      total++; if (om !== em) begin bad++; $display("FAIL frame_msb c%0d got=%b exp=%b", i, om, em); end
      total++; if (ol !== el) begin bad++; $display("FAIL frame_lsb c%0d got=%b exp=%b", i, ol, el); end
      nxt();
    end
    #1;
    total++; if (om !== 6'b000011) begin bad++; $display("FAIL frame_done_m got=%b exp=%b", om, 6'b000011); end
    total++; if (ol !== 6'b100011) begin bad++; $display("FAIL frame_done_l got=%b exp=%b", ol, 6'b100011); end
    nxt(); #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL frame_done_drop got=%b exp=%b", om, 6'b000001); end
  endtask

  task automatic test_slow_tick();
    logic [7:0] ba;
    int k;
    ba = 8'b10100101;
    d = 8'hA5; load_valid = 1'b1; shift_en = 1'b0; #1;
    total++; if (lr_m !== 1'b1) begin bad++; $display("FAIL slow_ready got=%b exp=1", lr_m); end
    nxt();
    load_valid = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      shift_en = (j % 3 == 0);
      #1;
      k = (j - 1) / 3;
      em = {ba[7-k], 1'b1, k == 0, k == 7, 1'b0, j == 24};
      total++; if (om !== em) begin bad++; $display("FAIL slow_msb c%0d got=%b exp=%b", j, om, em); end
      total++; if (ol !== em) begin bad++; $display("FAIL slow_lsb c%0d got=%b exp=%b", j, ol, em); end
      nxt();
    end
    shift_en = 1'b0; #1;
    total++; if (om !== 6'b000011) begin bad++; $display("FAIL slow_done got=%b exp=%b", om, 6'b000011); end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [15:0] sm, sl;
    sm = 16'b1111000000001111;
    sl = 16'b0000111111110000;
    d = 8'hF0; load_valid = 1'b1; shift_en = 1'b1; #1;
    total++; if (lr_m !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", lr_m); end
    nxt();
    d = 8'h0F;
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) load_valid = 1'b0;
      #1;
      em = {sm[16-i], 1'b1, i == 1 || i == 9, i == 8 || i == 16, i == 9, i == 8 || i == 16};
      el = {sl[16-i], 1'b1, i == 1 || i == 9, i == 8 || i == 16, i == 9, i == 8 || i == 16};
      total++; if (om !== em) begin bad++; $display("FAIL b2b_msb c%0d got=%b exp=%b", i, om, em); end
      total++; if (ol !== el) begin bad++; $display("FAIL b2b_lsb c%0d got=%b exp=%b", i, ol, el); end
      nxt();
    end
    #1;
    total++; if (om !== 6'b000011) begin bad++; $display("FAIL b2b_done_m got=%b exp=%b", om, 6'b000011); end
    total++; if (ol !== 6'b100011) begin bad++; $display("FAIL b2b_done_l got=%b exp=%b", ol, 6'b100011); end
    nxt();
  endtask

  task automatic test_reset_mid();
    d = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
    nxt();
    load_valid = 1'b0;
    nxt(); nxt(); nxt(); #1;
    total++; if (om !== 6'b110000) begin bad++; $display("FAIL mid_bit3 got=%b exp=%b", om, 6'b110000); end
    reset = 1'b0; #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL mid_reset_m got=%b exp=%b", om, 6'b000001); end
    total++; if (ol !== 6'b100001) begin bad++; $display("FAIL mid_reset_l got=%b exp=%b", ol, 6'b100001); end
    nxt();
    reset = 1'b1; #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL mid_no_done1 got=%b exp=%b", om, 6'b000001); end
    nxt(); #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL mid_no_done2 got=%b exp=%b", om, 6'b000001); end
    d = 8'h81; load_valid = 1'b1;
    nxt();
    load_valid = 1'b0; #1;
    total++; if (om !== 6'b111000) begin bad++; $display("FAIL mid_restart_m got=%b exp=%b", om, 6'b111000); end
    total++; if (ol !== 6'b111000) begin bad++; $display("FAIL mid_restart_l got=%b exp=%b", ol, 6'b111000); end
    nxt(); #1;
    total++; if (om !== 6'b010000) begin bad++; $display("FAIL mid_restart_b1 got=%b exp=%b", om, 6'b010000); end
    flush = 1'b1; #1;
    total++; if (lr_m !== 1'b0) begin bad++; $display("FAIL mid_flush_ready got=%b exp=0", lr_m); end
    nxt();
    flush = 1'b0; #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL mid_flush_idle got=%b exp=%b", om, 6'b000001); end
  endtask

  task automatic test_flush();
    d = 8'h3C; load_valid = 1'b1; shift_en = 1'b1;
    nxt();
    load_valid = 1'b0;
    repeat (7) nxt();
    flush = 1'b1; load_valid = 1'b1; d = 8'hC3; #1;
    total++; if (om !== 6'b010100) begin bad++; $display("FAIL flush_last_m got=%b exp=%b", om, 6'b010100); end
    total++; if (ol !== 6'b010100) begin bad++; $display("FAIL flush_last_l got=%b exp=%b", ol, 6'b010100); end
    nxt();
    flush = 1'b0; #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL flush_idle got=%b exp=%b", om, 6'b000001); end
    nxt();
    load_valid = 1'b0; #1;
    total++; if (om !== 6'b111000) begin bad++; $display("FAIL flush_reload_m got=%b exp=%b", om, 6'b111000); end
    total++; if (ol !== 6'b111000) begin bad++; $display("FAIL flush_reload_l got=%b exp=%b", ol, 6'b111000); end
    flush = 1'b1;
    nxt();
    flush = 1'b0; #1;
    total++; if (om !== 6'b000001) begin bad++; $display("FAIL flush_end got=%b exp=%b", om, 6'b000001); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_slow_tick();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
